// File: rtl/reaction_round_scheduler.sv
// Reaction-game round sequencer: ms prescaler, LFSR wait/target, windowed judging, score/level/lives.
// Optional: define FAST_HIT_BONUS_EN to award +2 for hits landed in the first quarter of the window.
module reaction_round_scheduler #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned LED_NUM         = 18,
  parameter int unsigned MIN_WAIT_MS     = 500,
  parameter int unsigned BASE_WINDOW_MS  = 1000,
  parameter int unsigned WINDOW_STEP_MS  = 200,
  parameter int unsigned MIN_WINDOW_MS   = 200,
  parameter int unsigned LIVES           = 3,
  parameter int unsigned SCORE_PER_LEVEL = 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [LED_NUM-1:0]           switches,
  output logic [LED_NUM-1:0]           target_led,
  output logic [$clog2(LED_NUM)-1:0]   target_idx,
  output logic [10:0]                  window_ms,
  output logic                         round_active,
  output logic [6:0]                   score,
  output logic [4:0]                   level,
  output logic [$clog2(LIVES+1)-1:0]   lives_left,
  output logic                         game_over,
  output logic                         ms_tick
);

  localparam int unsigned DIV    = CLK_HZ / 1000;
  localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W  = $clog2(LED_NUM);
  localparam int unsigned LIV_W  = $clog2(LIVES + 1);
  localparam int unsigned WAIT_W = 16;
  localparam int unsigned WIN_W  = 11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_HIT   = 3'd3;
  localparam logic [2:0] S_MISS  = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  logic [2:0]         state, state_nxt;
  logic [PRE_W-1:0]   presc, presc_nxt;
  logic [15:0]        lfsr;
  logic               start_q, start_edge;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic [WIN_W-1:0]   win_cnt, win_nxt;
  logic [LED_NUM-1:0] sw_ref, sw_ref_nxt, delta, led_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [5:0]         idx_raw, idx_sel;
  logic [6:0]         score_q, score_nxt, score_hit, lvl_div;
  logic [7:0]         score_sum;
  logic [4:0]         level_q, level_nxt, level_hit;
  logic [LIV_W-1:0]   lives_q, lives_nxt;
  logic signed [15:0] win_s;
  logic [1:0]         hit_add;

`ifdef FAST_HIT_BONUS_EN
  logic        fast_q, fast_nxt;
  logic [12:0] win_x3;
  assign win_x3  = 13'(window_ms) * 13'd3;
  assign hit_add = fast_q ? 2'd2 : 2'd1;
`else
  assign hit_add = 2'd1;
`endif

  assign start_edge = start & ~start_q;
  assign delta      = switches ^ sw_ref;
  assign presc_nxt  = (presc == PRE_W'(DIV - 1)) ? '0 : presc + PRE_W'(1);
  assign idx_raw    = {1'b0, lfsr[15:11]};
  assign idx_sel    = (idx_raw >= 6'(LED_NUM)) ? idx_raw - 6'(LED_NUM) : idx_raw;
  assign score_sum  = {1'b0, score_q} + 8'(hit_add);
  assign score_hit  = (score_sum > 8'd99) ? 7'd99 : 7'(score_sum);
  assign lvl_div    = score_hit / 7'(SCORE_PER_LEVEL);
  assign level_hit  = (lvl_div > 7'd31) ? 5'd31 : 5'(lvl_div);

  assign score      = score_q;
  assign level      = level_q;
  assign lives_left = lives_q;

  // Window shrinks with level; signed math so large levels clamp instead of wrapping.
  always_comb begin
    win_s = $signed(16'(BASE_WINDOW_MS)) - $signed(16'(WINDOW_STEP_MS) * 16'(level_q));
    if (win_s < $signed(16'(MIN_WINDOW_MS))) window_ms = WIN_W'(MIN_WINDOW_MS);
    else                                     window_ms = WIN_W'(win_s);
  end

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    win_nxt    = win_cnt;
    sw_ref_nxt = sw_ref;
    idx_nxt    = target_idx;
    score_nxt  = score_q;
    level_nxt  = level_q;
    lives_nxt  = lives_q;
    led_nxt    = '0;
`ifdef FAST_HIT_BONUS_EN
    fast_nxt   = fast_q;
`endif
    case (state)
      S_IDLE: if (start_edge) begin
        state_nxt = S_WAIT;
        score_nxt = '0;
        level_nxt = '0;
        lives_nxt = LIV_W'(LIVES);
      end
      S_WAIT: if (ms_tick) begin
        if (wait_cnt <= WAIT_W'(1)) state_nxt = S_ARMED;
        else                        wait_nxt  = wait_cnt - WAIT_W'(1);
      end
      // Hit is checked first so a correct toggle on the expiry tick still scores.
      S_ARMED: begin
        if (delta == target_led) begin
          state_nxt = S_HIT;
`ifdef FAST_HIT_BONUS_EN
          fast_nxt  = 13'(win_cnt) > (win_x3 >> 2);
`endif
        end else if (|delta) begin
          state_nxt = S_MISS;
        end else if (ms_tick) begin
          if (win_cnt <= WIN_W'(1)) state_nxt = S_MISS;
          else                      win_nxt   = win_cnt - WIN_W'(1);
        end
      end
      S_HIT: begin
        state_nxt = S_WAIT;
        score_nxt = score_hit;
        level_nxt = level_hit;
      end
      S_MISS: begin
        lives_nxt = (lives_q != '0) ? lives_q - LIV_W'(1) : '0;
        state_nxt = (lives_q <= LIV_W'(1)) ? S_OVER : S_WAIT;
      end
      S_OVER: if (start_edge) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt == S_WAIT && state != S_WAIT) begin
      wait_nxt = WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr[9:0]);
      idx_nxt  = IDX_W'(idx_sel);
    end
    if (state_nxt == S_ARMED && state != S_ARMED) begin
      sw_ref_nxt = switches;
      win_nxt    = window_ms;
    end
    if (state_nxt == S_ARMED) led_nxt = LED_NUM'(1) << idx_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      presc        <= '0;
      ms_tick      <= 1'b0;
      lfsr         <= 16'hACE1;
      start_q      <= 1'b0;
      wait_cnt     <= '0;
      win_cnt      <= '0;
      sw_ref       <= '0;
      target_idx   <= '0;
      target_led   <= '0;
      score_q      <= '0;
      level_q      <= '0;
      lives_q      <= LIV_W'(LIVES);
      round_active <= 1'b0;
      game_over    <= 1'b0;
`ifdef FAST_HIT_BONUS_EN
      fast_q       <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      presc        <= presc_nxt;
      ms_tick      <= (presc_nxt == PRE_W'(DIV - 1));
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      start_q      <= start;
      wait_cnt     <= wait_nxt;
      win_cnt      <= win_nxt;
      sw_ref       <= sw_ref_nxt;
      target_idx   <= idx_nxt;
      target_led   <= led_nxt;
      score_q      <= score_nxt;
      level_q      <= level_nxt;
      lives_q      <= lives_nxt;
      round_active <= (state_nxt == S_WAIT) || (state_nxt == S_ARMED);
      game_over    <= (state_nxt == S_OVER);
`ifdef FAST_HIT_BONUS_EN
      fast_q       <= fast_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_reaction_round_scheduler.sv
// Self-checking bench for reaction_round_scheduler: reference LFSR plus score/lives/window scoreboard.
module tb_reaction_round_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [17:0] switches = '0;
  logic [17:0] target_led;
  logic [4:0]  target_idx;
  logic [10:0] window_ms;
  logic        round_active;
  logic [6:0]  score;
  logic [4:0]  level;
  logic [1:0]  lives_left;
  logic        game_over;
  logic        ms_tick;

  int checks = 0;
  int errors = 0;
  int exp_score = 0;
  int exp_lives = 3;

  always #5 clk = ~clk;

  reaction_round_scheduler #(.CLK_HZ(4000)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .switches(switches),
    .target_led(target_led), .target_idx(target_idx), .window_ms(window_ms),
    .round_active(round_active), .score(score), .level(level),
    .lives_left(lives_left), .game_over(game_over), .ms_tick(ms_tick)
  );

  // Reference LFSR; entry_lfsr holds the value seen in the cycle a round's wait began.
  logic [15:0] m_lfsr, m_prev, entry_lfsr;
  logic        ra_prev;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end
  always @(negedge clk) begin
    if (round_active && !ra_prev) entry_lfsr <= m_prev;
    ra_prev <= round_active;
  end

  function automatic int exp_wait();
    return 500 + int'(entry_lfsr[9:0]);
  endfunction
  function automatic int exp_idx();
    return int'(entry_lfsr[15:11]) % 18;
  endfunction
  function automatic int exp_window(input int sc);
    int lv = sc / 5;
    int w;
    if (lv > 31) lv = 31;
    w = 1000 - 200 * lv;
    return (w < 200) ? 200 : w;
  endfunction

  task automatic start_pulse;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_armed(output int ticks, output bit ok);
    ticks = 0; ok = 1'b0;
    for (int n = 0; n < 8000; n++) begin
      if (target_led != '0) begin ok = 1'b1; break; end
      if (round_active && ms_tick) ticks++;
      @(negedge clk);
    end
  endtask

  task automatic toggle_after(input int nticks, input int bit_idx);
    int seen = 0;
    for (int n = 0; n < 8000; n++) begin
      if (ms_tick) seen++;
      if (seen >= nticks) break;
      @(negedge clk);
    end
    switches[bit_idx] = ~switches[bit_idx];
    @(negedge clk);
  endtask

  task automatic wait_timeout(output int ticks, output bit ok);
    ticks = 0; ok = 1'b0;
    for (int n = 0; n < 8000; n++) begin
      if (target_led == '0) begin ok = 1'b1; break; end
      if (ms_tick) ticks++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int ticks = 0, last = -1, bad = 0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (lives_left !== 2'd3) begin errors++; $display("FAIL reset_lives got %0d exp 3", lives_left); end
    checks++; if (score !== 7'd0) begin errors++; $display("FAIL reset_score got %0d exp 0", score); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (window_ms !== 11'd1000) begin errors++; $display("FAIL reset_window got %0d exp 1000", window_ms); end
    checks++; if ({round_active, game_over, ms_tick} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {round_active, game_over, ms_tick}); end
    checks++; if (target_led !== '0) begin errors++; $display("FAIL reset_led got %h exp 0", target_led); end
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ms_tick) begin
        if (last >= 0 && c - last != 4) bad++;
        last = c; ticks++;
      end
    end
    checks++; if (ticks != 10) begin errors++; $display("FAIL ms_tick_count got %0d exp 10", ticks); end
    checks++; if (bad != 0) begin errors++; $display("FAIL ms_tick_period bad_gaps %0d exp 0", bad); end
    checks++; if (round_active !== 1'b0) begin errors++; $display("FAIL idle_hold got %b exp 0", round_active); end
    exp_score = 0; exp_lives = 3;
  endtask

  task automatic test_first_round;
    int t; bit ok; logic [17:0] oh;
    start_pulse;
    checks++; if (round_active !== 1'b1) begin errors++; $display("FAIL start_active got %b exp 1", round_active); end
    wait_armed(t, ok);
    oh = '0; oh[exp_idx()] = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL arm_timeout led %h exp nonzero", target_led); end
    checks++; if (t != exp_wait()) begin errors++; $display("FAIL wait_ms got %0d exp %0d", t, exp_wait()); end
    checks++; if (int'(target_idx) != exp_idx()) begin errors++; $display("FAIL target_idx got %0d exp %0d", target_idx, exp_idx()); end
    checks++; if (!(target_idx < 5'd18)) begin errors++; $display("FAIL idx_range got %0d exp <18", target_idx); end
    checks++; if (target_led !== oh) begin errors++; $display("FAIL target_led got %h exp %h", target_led, oh); end
  endtask

  task automatic test_hit;
    toggle_after(100, exp_idx());
    checks++; if (target_led !== '0) begin errors++; $display("FAIL hit_led_clear got %h exp 0", target_led); end
    checks++; if (int'(score) != exp_score) begin errors++; $display("FAIL hit_score_early got %0d exp %0d", score, exp_score); end
    @(negedge clk); exp_score++;
    checks++; if (int'(score) != exp_score) begin errors++; $display("FAIL hit_score got %0d exp %0d", score, exp_score); end
    checks++; if (round_active !== 1'b1) begin errors++; $display("FAIL hit_back_to_wait got %b exp 1", round_active); end
  endtask

  task automatic test_lives;
    int t, wrong; bit ok;
    wait_armed(t, ok);
    checks++; if (t != exp_wait()) begin errors++; $display("FAIL wait2_ms got %0d exp %0d", t, exp_wait()); end
    wrong = (exp_idx() + 1 + int'($urandom_range(0, 16))) % 18;
    toggle_after(int'($urandom_range(0, 50)), wrong);
    checks++; if (target_led !== '0) begin errors++; $display("FAIL wrong_led_clear got %h exp 0", target_led); end
    @(negedge clk); exp_lives--;
    checks++; if (int'(lives_left) != exp_lives) begin errors++; $display("FAIL wrong_lives got %0d exp %0d", lives_left, exp_lives); end
    for (int r = 0; r < 2; r++) begin
      wait_armed(t, ok);
      wait_timeout(t, ok);
      checks++; if (!ok || t != exp_window(exp_score)) begin errors++; $display("FAIL timeout_ms got %0d exp %0d", t, exp_window(exp_score)); end
      @(negedge clk); exp_lives--;
      checks++; if (int'(lives_left) != exp_lives) begin errors++; $display("FAIL timeout_lives got %0d exp %0d", lives_left, exp_lives); end
    end
    checks++; if ({game_over, round_active} !== 2'b10) begin errors++; $display("FAIL over_flags got %b exp 10", {game_over, round_active}); end
    start_pulse;
    checks++; if ({game_over, round_active} !== 2'b00) begin errors++; $display("FAIL over_to_idle got %b exp 00", {game_over, round_active}); end
    checks++; if (int'(score) != exp_score) begin errors++; $display("FAIL frozen_score got %0d exp %0d", score, exp_score); end
    start_pulse; exp_score = 0; exp_lives = 3;
    checks++; if (score !== 7'd0 || lives_left !== 2'd3) begin errors++; $display("FAIL restart got score %0d lives %0d exp 0 3", score, lives_left); end
  endtask

  task automatic forced_hit(input int preset, input string name);
    int t; bit ok;
    force dut.score_q = 7'(preset);
    @(negedge clk);
    release dut.score_q;
    exp_score = preset;
    wait_armed(t, ok);
    checks++; if (!ok || int'(target_idx) != exp_idx()) begin errors++; $display("FAIL %s_idx got %0d exp %0d", name, target_idx, exp_idx()); end
    toggle_after(int'($urandom_range(1, 150)), exp_idx());
    @(negedge clk);
    exp_score = (exp_score + 1 > 99) ? 99 : exp_score + 1;
    checks++; if (int'(score) != exp_score) begin errors++; $display("FAIL %s_score got %0d exp %0d", name, score, exp_score); end
    checks++; if (int'(level) != exp_score / 5) begin errors++; $display("FAIL %s_level got %0d exp %0d", name, level, exp_score / 5); end
    checks++; if (int'(window_ms) != exp_window(exp_score)) begin errors++; $display("FAIL %s_window got %0d exp %0d", name, window_ms, exp_window(exp_score)); end
  endtask

  task automatic test_level_window;
    forced_hit(19, "level4");
  endtask

  task automatic test_expiry_hit;
    int t; bit ok;
    wait_armed(t, ok);
    checks++; if (t != exp_wait()) begin errors++; $display("FAIL wait3_ms got %0d exp %0d", t, exp_wait()); end
    toggle_after(exp_window(exp_score), exp_idx());
    checks++; if (target_led !== '0) begin errors++; $display("FAIL expiry_led got %h exp 0", target_led); end
    @(negedge clk); exp_score++;
    checks++; if (int'(score) != exp_score) begin errors++; $display("FAIL expiry_score got %0d exp %0d", score, exp_score); end
    checks++; if (int'(lives_left) != exp_lives) begin errors++; $display("FAIL expiry_lives got %0d exp %0d", lives_left, exp_lives); end
  endtask

  task automatic test_level5_clamp;
    forced_hit(24, "level5");
  endtask

  task automatic test_saturate;
    forced_hit(99, "sat");
  endtask

  task automatic test_reset_mid;
    int t; bit ok;
    wait_armed(t, ok);
    repeat (int'($urandom_range(1, 20))) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (target_led !== '0) begin errors++; $display("FAIL midreset_led got %h exp 0", target_led); end
    checks++; if (lives_left !== 2'd3 || score !== 7'd0) begin errors++; $display("FAIL midreset_vals got lives %0d score %0d exp 3 0", lives_left, score); end
    checks++; if (window_ms !== 11'd1000 || round_active !== 1'b0) begin errors++; $display("FAIL midreset_win got %0d act %b exp 1000 0", window_ms, round_active); end
    @(negedge clk) reset_n = 1'b1;
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_first_round;
    test_hit;
    test_lives;
    test_level_window;
    test_expiry_hit;
    test_level5_clamp;
    test_saturate;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
